// File: rtl/muldiv_sched.sv
// Scheduler that shares one iterative 8x8 multiply / 16/8 divide unit between two requesters.
// It grants a job by round-robin, writes the operands, waits out the iterations and reads the result back.
package bus_pkg;
  typedef enum logic [3:0] {
    A_NONE, A_WRMPYA, A_WRMPYB, A_WRDIVL, A_WRDIVH, A_WRDIVB,
    A_RDMPYL, A_RDMPYH, A_RDDIVL, A_RDDIVH
  } a_op_type;
endpackage

module muldiv_sched #(
  parameter int MUL_CYC = 8,
  parameter int DIV_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [1:0]        req,
  input  logic [1:0]        is_div,
  input  logic [15:0]       opa0,
  input  logic [15:0]       opa1,
  input  logic [7:0]        opb0,
  input  logic [7:0]        opb1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [15:0]       res_a,
  output logic [15:0]       res_b,
  output bus_pkg::a_op_type a_op,
  output logic [7:0]        wdata,
  input  logic [7:0]        rdata
);
  import bus_pkg::*;

  // state | meaning
  // IDLE  | waiting for a request; grants and latches operands
  // LDA/LDH/LDB | writing operand A (low/high) and operand B to the unit
  // WAIT  | unit iterating; counter runs down to 0
  // RD0-3 | reading result bytes; the last read publishes the result and pulses done
  typedef enum logic [3:0] {IDLE, LDA, LDH, LDB, WAIT, RD0, RD1, RD2, RD3} state_t;

  localparam int CMAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = $clog2(CMAX) + 1;

  state_t        state;
  logic          last;
  logic          gnt;
  logic          pick;
  logic          op_div;
  logic [15:0]   op_a;
  logic [7:0]    op_b;
  logic [CW-1:0] cnt;
  logic [7:0]    cap0, cap1, cap2;

  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) pick = ~last;
    else if (req[1])  pick = 1'b1;
  end

  always_comb begin
    a_op  = A_NONE;
    wdata = 8'h00;
    case (state)
      LDA: begin
        a_op  = op_div ? A_WRDIVL : A_WRMPYA;
        wdata = op_a[7:0];
      end
      LDH: begin
        a_op  = A_WRDIVH;
        wdata = op_a[15:8];
      end
      LDB: begin
        a_op  = op_div ? A_WRDIVB : A_WRMPYB;
        wdata = op_b;
      end
      RD0:     a_op = op_div ? A_RDDIVL : A_RDMPYL;
      RD1:     a_op = op_div ? A_RDDIVH : A_RDMPYH;
      RD2:     a_op = A_RDMPYL;
      RD3:     a_op = A_RDMPYH;
      default: a_op = A_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      gnt    <= 1'b0;
      op_div <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      cap0   <= '0;
      cap1   <= '0;
      cap2   <= '0;
      ack    <= '0;
      done   <= '0;
      res_a  <= '0;
      res_b  <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      if (cpu_en) begin
        case (state)
          IDLE: if (|req) begin
            gnt       <= pick;
            last      <= pick;
            op_div    <= pick ? is_div[1] : is_div[0];
            op_a      <= pick ? opa1 : opa0;
            op_b      <= pick ? opb1 : opb0;
            ack[pick] <= 1'b1;
            state     <= LDA;
          end
          LDA: state <= op_div ? LDH : LDB;
          LDH: state <= LDB;
          LDB: begin
            cnt   <= op_div ? CW'(DIV_CYC - 1) : CW'(MUL_CYC - 1);
            state <= WAIT;
          end
          WAIT: begin
            if (cnt == '0) state <= RD0;
            else           cnt   <= cnt - CW'(1);
          end
          RD0: begin
            cap0  <= rdata;
            state <= RD1;
          end
          RD1: begin
            if (op_div) begin
              cap1  <= rdata;
              state <= RD2;
            end else begin
              res_a     <= {rdata, cap0};
              res_b     <= '0;
              done[gnt] <= 1'b1;
              state     <= IDLE;
            end
          end
          RD2: begin
            cap2  <= rdata;
            state <= RD3;
          end
          RD3: begin
            res_a     <= {cap1, cap0};
            res_b     <= {rdata, cap2};
            done[gnt] <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
